vga_timing_gen: RTL and testbench

// - Raster timing generator for the VGA pixel pipeline; it drives the pixel consumers (sprite/cursor drawers).
// - Produces DrawX/DrawY coordinates, a display-active "blank" flag (1 = visible pixel), and hsync/vsync.
// - Also produces line_end/frame_start strobes. Default mode is 640x480@60 Hz on the 25 MHz vga_clk.

---
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with horizontal and vertical phase FSMs.
// Every output is registered and decoded from the next-state counters so all outputs stay aligned.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] H_FP_LAST  = 10'(H_VISIBLE + H_FRONT - 1);
  localparam logic [9:0] H_SY_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_FP_LAST  = 10'(V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0] V_SY_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_VIS, H_FP, H_SY, H_BP} h_state_e;
  typedef enum logic [1:0] {V_VIS, V_FP, V_SY, V_BP} v_state_e;

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic       blank_q, blank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_end_q, line_end_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap_s, v_wrap_s;

  // Counter next-state; any out-of-range count wraps to 0 on the next edge.
  always_comb begin
    h_wrap_s = (hc_q >= H_LAST);
    v_wrap_s = (vc_q > V_LAST) || (h_wrap_s && (vc_q == V_LAST));
    if (h_wrap_s) begin
      hc_d = 10'd0;
    end else begin
      hc_d = hc_q + 10'd1;
    end
    if (v_wrap_s) begin
      vc_d = 10'd0;
    end else if (h_wrap_s) begin
      vc_d = vc_q + 10'd1;
    end else begin
      vc_d = vc_q;
    end
  end

  // Horizontal phase FSM, stepped by the column counter.
  always_comb begin
    h_state_d = h_state_q;
    if (h_wrap_s) begin
      h_state_d = H_VIS;
    end else begin
      case (h_state_q)
        H_VIS:   if (hc_q == H_VIS_LAST) h_state_d = H_FP; else h_state_d = H_VIS;
        H_FP:    if (hc_q == H_FP_LAST)  h_state_d = H_SY; else h_state_d = H_FP;
        H_SY:    if (hc_q == H_SY_LAST)  h_state_d = H_BP; else h_state_d = H_SY;
        H_BP:    h_state_d = H_BP;
        default: h_state_d = H_VIS;
      endcase
    end
  end

  // Vertical phase FSM; only moves on the edge where the line wraps.
  always_comb begin
    v_state_d = v_state_q;
    if (v_wrap_s) begin
      v_state_d = V_VIS;
    end else if (h_wrap_s) begin
      case (v_state_q)
        V_VIS:   if (vc_q == V_VIS_LAST) v_state_d = V_FP; else v_state_d = V_VIS;
        V_FP:    if (vc_q == V_FP_LAST)  v_state_d = V_SY; else v_state_d = V_FP;
        V_SY:    if (vc_q == V_SY_LAST)  v_state_d = V_BP; else v_state_d = V_SY;
        V_BP:    v_state_d = V_BP;
        default: v_state_d = V_VIS;
      endcase
    end else begin
      v_state_d = v_state_q;
    end
  end

  // Output decode from next-state values so flags line up with the coordinates.
  always_comb begin
    blank_d       = (h_state_d == H_VIS) && (v_state_d == V_VIS);
    hsync_d       = (h_state_d == H_SY) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_state_d == V_SY) ? SYNC_POL : ~SYNC_POL;
    line_end_d    = (hc_d == H_LAST);
    frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
  end

  // State and output registers; reset values equal the decode of count (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      h_state_q     <= H_VIS;
      v_state_q     <= V_VIS;
      blank_q       <= 1'b1;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, a small-raster instance for frame timing.
module tb_vga_timing_gen;

  typedef struct {
    int x; int y; int blank; int hs; int vs; int le; int fs;
  } obs_t;

  typedef struct {
    int cyc; int x; int y; int blank; int hs; int vs; int le; int fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  logic [9:0] ax, ay, bx, by;
  logic ab, ahs, avs, ale, afs;
  logic bb, bhs, bvs, ble, bfs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .vga_clk(clk), .reset_n(rst_a_n), .DrawX(ax), .DrawY(ay), .blank(ab),
    .hsync(ahs), .vsync(avs), .line_end(ale), .frame_start(afs)
  );

  // Small raster: 15 columns x 10 lines, active-high syncs.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b1)
  ) u_b (
    .vga_clk(clk), .reset_n(rst_b_n), .DrawX(bx), .DrawY(by), .blank(bb),
    .hsync(bhs), .vsync(bvs), .line_end(ble), .frame_start(bfs)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".x"}, a.x, e.x);
    chk({tag, ".y"}, a.y, e.y);
    chk({tag, ".blank"}, a.blank, e.blank);
    chk({tag, ".hsync"}, a.hs, e.hs);
    chk({tag, ".vsync"}, a.vs, e.vs);
    chk({tag, ".line_end"}, a.le, e.le);
    chk({tag, ".frame_start"}, a.fs, e.fs);
  endtask

  function automatic obs_t get_a();
    obs_t o;
    o.x = int'(ax); o.y = int'(ay); o.blank = int'(ab); o.hs = int'(ahs);
    o.vs = int'(avs); o.le = int'(ale); o.fs = int'(afs);
    return o;
  endfunction

  function automatic obs_t get_b();
    obs_t o;
    o.x = int'(bx); o.y = int'(by); o.blank = int'(bb); o.hs = int'(bhs);
    o.vs = int'(bvs); o.le = int'(ble); o.fs = int'(bfs);
    return o;
  endfunction

  // Reference: position t clocks after reset release, decoded straight from the raster geometry.
  function automatic obs_t model(input int t, input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb, input int pol);
    obs_t o;
    int ht, vt, tf;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    tf = t % (ht * vt);
    o.x = tf % ht;
    o.y = tf / ht;
    o.blank = (o.x < hv && o.y < vv) ? 1 : 0;
    o.hs = (o.x >= hv + hf && o.x < hv + hf + hsw) ? pol : 1 - pol;
    o.vs = (o.y >= vv + vf && o.y < vv + vf + vsw) ? pol : 1 - pol;
    o.le = (o.x == ht - 1) ? 1 : 0;
    o.fs = (o.x == 0 && o.y == 0) ? 1 : 0;
    return o;
  endfunction

  function automatic obs_t model_a(input int t);
    return model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0);
  endfunction

  function automatic obs_t model_b(input int t);
    return model(t, 8, 2, 3, 2, 5, 1, 2, 2, 1);
  endfunction

  task automatic pulse_reset_a();
    @(negedge clk);
    rst_a_n = 1'b0;
    #1;
    rst_a_n = 1'b1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[12];
    obs_t rst_a_exp, rst_b_exp, e;
    int cur, hs_cnt, le_cnt, bl_cnt, vs_cnt, fs_mid, ymax, n;

    tbl[0]  = '{0,    0,   0, 1, 1, 1, 0, 1};
    tbl[1]  = '{1,    1,   0, 1, 1, 1, 0, 0};
    tbl[2]  = '{639,  639, 0, 1, 1, 1, 0, 0};
    tbl[3]  = '{640,  640, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{655,  655, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{656,  656, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{751,  751, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{752,  752, 0, 0, 1, 1, 0, 0};
    tbl[8]  = '{799,  799, 0, 0, 1, 1, 1, 0};
    tbl[9]  = '{800,  0,   1, 1, 1, 1, 0, 0};
    tbl[10] = '{1439, 639, 1, 1, 1, 1, 0, 0};
    tbl[11] = '{1456, 656, 1, 0, 0, 1, 0, 0};

    rst_a_exp = '{0, 0, 1, 1, 1, 0, 1};
    rst_b_exp = '{0, 0, 1, 0, 0, 0, 1};

    // Reset held for 5 clocks
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_obs("reset_a", get_a(), rst_a_exp);
    chk_obs("reset_b", get_b(), rst_b_exp);

    // Table-driven line timing on the default instance
    rst_a_n = 1'b1;
    #1;
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      while (cur < tbl[i].cyc) begin
        @(negedge clk);
        cur++;
      end
      e = '{tbl[i].x, tbl[i].y, tbl[i].blank, tbl[i].hs, tbl[i].vs, tbl[i].le, tbl[i].fs};
      chk_obs($sformatf("vec%0d", i), get_a(), e);
    end

    // Three lines of the default instance against the model, with line-0 counts
    pulse_reset_a();
    hs_cnt = 0; le_cnt = 0; bl_cnt = 0;
    for (int t = 0; t < 2400; t++) begin
      if (t > 0) @(negedge clk);
      chk_obs("sb_a", get_a(), model_a(t));
      if (t < 800) begin
        if (ahs == 1'b0) hs_cnt++;
        if (ale == 1'b1) le_cnt++;
        if (ab == 1'b1)  bl_cnt++;
      end
    end
    chk("line_hsync_cycles", hs_cnt, 96);
    chk("line_end_count", le_cnt, 1);
    chk("line_blank_cycles", bl_cnt, 640);

    // Mid-line reset between clock edges on the default instance
    pulse_reset_a();
    for (int t = 1; t <= 1900; t++) @(negedge clk);
    chk_obs("pre_reset_a", get_a(), model_a(1900));
    #2;
    rst_a_n = 1'b0;
    #1;
    chk_obs("async_reset_a", get_a(), rst_a_exp);
    @(negedge clk);
    rst_a_n = 1'b1;
    #1;
    chk_obs("restart_a0", get_a(), rst_a_exp);
    @(negedge clk);
    chk_obs("restart_a1", get_a(), model_a(1));

    // Small raster: three frames plus wrap corner
    @(negedge clk);
    rst_b_n = 1'b1;
    #1;
    vs_cnt = 0; fs_mid = 0; ymax = 0;
    for (int t = 0; t <= 450; t++) begin
      if (t > 0) @(negedge clk);
      chk_obs("sb_b", get_b(), model_b(t));
      if (t < 150 && bvs == 1'b1) vs_cnt++;
      if (t > 0 && t < 150 && bfs == 1'b1) fs_mid++;
      if (int'(by) > ymax) ymax = int'(by);
      if (t == 149) begin
        chk("wrap_pre_x", int'(bx), 14);
        chk("wrap_pre_y", int'(by), 9);
        chk("wrap_pre_le", int'(ble), 1);
      end
      if (t == 150) begin
        chk("wrap_x", int'(bx), 0);
        chk("wrap_y", int'(by), 0);
        chk("wrap_fs", int'(bfs), 1);
        chk("wrap_le", int'(ble), 0);
        chk("wrap_blank", int'(bb), 1);
      end
    end
    chk("frame_vsync_cycles", vs_cnt, 30);
    chk("frame_start_midframe", fs_mid, 0);
    chk("frame_max_y", ymax, 9);

    // Mid-frame reset on the small raster, then time to the next frame_start
    for (int t = 451; t <= 502; t++) @(negedge clk);
    chk_obs("pre_reset_b", get_b(), model_b(502));
    #2;
    rst_b_n = 1'b0;
    #1;
    chk_obs("async_reset_b", get_b(), rst_b_exp);
    @(negedge clk);
    rst_b_n = 1'b1;
    #1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bfs != 1'b1 && n < 400);
    chk("restart_frame_period", n, 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
